// File: rtl/aes_stream_adapter.sv
// Word-serial key/text loader and result streamer around the AES128 core.
// Optional key reuse across jobs is built when AES_KEY_CACHE_EN is defined.
module aes_stream_adapter #(
   parameter int DONE_TIMEOUT = 1023,
   parameter int TO_W         = 10
) (
   input  logic         i_Clk,
   input  logic         i_Rst,
   input  logic [31:0]  i_InData,
   input  logic         i_fInValid,
   input  logic         i_fInEnc,
`ifdef AES_KEY_CACHE_EN
   input  logic         i_fInKeyKeep,
`endif
   output logic         o_fInReady,
   output logic [127:0] o_Key,
   output logic [127:0] o_Text,
   output logic         o_fEnc,
   output logic         o_fStart,
   input  logic [127:0] i_AesData,
   input  logic         i_fAesDone,
   output logic [31:0]  o_OutData,
   output logic         o_fOutValid,
   output logic         o_fOutLast,
   input  logic         i_fOutReady,
   output logic         o_fTimeout
);

   typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

   state_t          state, state_n;
   logic [2:0]      idx, idx_n, wr_idx;
   logic [TO_W-1:0] cnt, cnt_n;
   logic [127:0]    result;
   logic            in_fire, cap, to_set, skip;

   function automatic logic [127:0] put_word(
      input logic [127:0] v,
      input logic [1:0]   i,
      input logic [31:0]  w
   );
      logic [127:0] r;
      r = v;
      unique case (i)
         2'd0: r[127:96] = w;
         2'd1: r[95:64]  = w;
         2'd2: r[63:32]  = w;
         2'd3: r[31:0]   = w;
      endcase
      return r;
   endfunction

`ifdef AES_KEY_CACHE_EN
   logic key_valid;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)
         key_valid <= 1'b0;
      else if (in_fire && wr_idx == 3'd3)
         key_valid <= 1'b1;
   end

   // A cached key lets word 0 land directly in text slot 0.
   assign skip = (idx == 3'd0) && i_fInKeyKeep && key_valid;
`else
   assign skip = 1'b0;
`endif

   assign wr_idx = skip ? 3'd4 : idx;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state <= LOAD;
         idx   <= 3'd0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      cnt_n       = cnt;
      in_fire     = 1'b0;
      cap         = 1'b0;
      to_set      = 1'b0;
      o_fInReady  = 1'b0;
      o_fStart    = 1'b0;
      o_fOutValid = 1'b0;
      o_fOutLast  = 1'b0;
      unique case (state)
         LOAD: begin
            o_fInReady = 1'b1;
            if (i_fInValid) begin
               in_fire = 1'b1;
               if (idx == 3'd7) begin
                  state_n = START;
                  idx_n   = 3'd0;
               end else begin
                  idx_n = skip ? 3'd5 : idx + 3'd1;
               end
            end
         end
         START: begin
            o_fStart = 1'b1;
            cnt_n    = '0;
            state_n  = WAIT;
         end
         WAIT: begin
            // Done has priority over an expiring timeout.
            if (i_fAesDone) begin
               cap     = 1'b1;
               state_n = SEND;
               idx_n   = 3'd0;
            end else if (cnt == TO_LAST) begin
               to_set  = 1'b1;
               state_n = LOAD;
               idx_n   = 3'd0;
            end else begin
               cnt_n = cnt + TO_W'(1);
            end
         end
         SEND: begin
            o_fOutValid = 1'b1;
            o_fOutLast  = (idx[1:0] == 2'd3);
            if (i_fOutReady) begin
               if (idx[1:0] == 2'd3) begin
                  state_n = LOAD;
                  idx_n   = 3'd0;
               end else begin
                  idx_n = idx + 3'd1;
               end
            end
         end
         default: state_n = LOAD;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Key      <= '0;
         o_Text     <= '0;
         o_fEnc     <= 1'b0;
         result     <= '0;
         o_fTimeout <= 1'b0;
      end else begin
         if (in_fire) begin
            if (wr_idx[2])
               o_Text <= put_word(o_Text, wr_idx[1:0], i_InData);
            else
               o_Key <= put_word(o_Key, wr_idx[1:0], i_InData);
            if (idx == 3'd0) begin
               o_fEnc     <= i_fInEnc;
               o_fTimeout <= 1'b0;
            end
         end
         if (cap)
            result <= i_AesData;
         if (to_set)
            o_fTimeout <= 1'b1;
      end
   end

   always_comb begin
      o_OutData = result[127:96];
      unique case (idx[1:0])
         2'd0: o_OutData = result[127:96];
         2'd1: o_OutData = result[95:64];
         2'd2: o_OutData = result[63:32];
         2'd3: o_OutData = result[31:0];
      endcase
   end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Randomized bench for aes_stream_adapter with a stand-in core.
// The stand-in core answers with a simple key/text mix after a chosen delay.
module tb_aes_stream_adapter;

   localparam int TO = 15;
`ifdef AES_KEY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_enc;
   logic         keep_in;
   logic         in_ready;
   logic [127:0] key;
   logic [127:0] text;
   logic         enc;
   logic         start;
   logic [127:0] aes_data;
   logic         aes_done;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_last;
   logic         out_ready;
   logic         timeout;

   int           n_chk = 0;
   int           n_pass = 0;

   bit           kv;
   logic [127:0] cached_key;
   bit           to_model;
   int           core_lat;

   always #5 clk = ~clk;

   aes_stream_adapter #(
      .DONE_TIMEOUT(TO),
      .TO_W(4)
   ) dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .i_InData(in_data),
      .i_fInValid(in_valid),
      .i_fInEnc(in_enc),
`ifdef AES_KEY_CACHE_EN
      .i_fInKeyKeep(keep_in),
`endif
      .o_fInReady(in_ready),
      .o_Key(key),
      .o_Text(text),
      .o_fEnc(enc),
      .o_fStart(start),
      .i_AesData(aes_data),
      .i_fAesDone(aes_done),
      .o_OutData(out_data),
      .o_fOutValid(out_valid),
      .o_fOutLast(out_last),
      .i_fOutReady(out_ready),
      .o_fTimeout(timeout)
   );

   task automatic check(
      input string        tag,
      input logic [127:0] got,
      input logic [127:0] exp
   );
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [127:0] core_fn(
      input logic [127:0] k,
      input logic [127:0] t,
      input logic         e
   );
      return {t[63:0], t[127:64]} ^ k ^ (e ? 128'h0 : {4{32'ha5a5a5a5}});
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Stand-in core: done arrives core_lat cycles into WAIT.
   initial begin
      logic [127:0] ck, ct;
      logic         ce;
      aes_done = 1'b0;
      aes_data = '0;
      forever begin
         @(negedge clk);
         if (start && !rst) begin
            ck = key;
            ct = text;
            ce = enc;
            @(negedge clk);
            repeat (core_lat) @(negedge clk);
            aes_data = core_fn(ck, ct, ce);
            aes_done = 1'b1;
            @(negedge clk);
            aes_done = 1'b0;
            aes_data = rnd128();
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_key"}, key, 128'h0);
      check({tag, "_text"}, text, 128'h0);
      check({tag, "_enc"}, 128'(enc), 128'h0);
      check({tag, "_start"}, 128'(start), 128'h0);
      check({tag, "_out_valid"}, 128'(out_valid), 128'h0);
      check({tag, "_out_last"}, 128'(out_last), 128'h0);
      check({tag, "_timeout"}, 128'(timeout), 128'h0);
      check({tag, "_in_ready"}, 128'(in_ready), 128'h1);
      check({tag, "_out_data"}, 128'(out_data), 128'h0);
   endtask

   task automatic job(input int lat, input bit keep_req);
      logic [31:0]  w[8];
      logic [127:0] k, t, exp_r;
      logic [31:0]  held;
      bit           e, use_c, timed, stalled;
      int           n, i, cyc, got, first;
      core_lat = lat;
      e = 1'($urandom_range(1));
      use_c = CACHE && keep_req && kv;
      k = use_c ? cached_key : rnd128();
      t = rnd128();
      n = use_c ? 4 : 8;
      for (int j = 0; j < 4; j++) begin
         w[j]   = k[127-32*j -: 32];
         w[j+4] = t[127-32*j -: 32];
      end
      i = 0;
      @(negedge clk);
      check("idle_out_valid", 128'(out_valid), 128'h0);
      while (i < n) begin
         check("timeout_flag", 128'(timeout), 128'(to_model));
         if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end else begin
            check("in_ready_load", 128'(in_ready), 128'h1);
            in_valid = 1'b1;
            in_data  = use_c ? w[i+4] : w[i];
            in_enc   = (i == 0) ? e : 1'($urandom_range(1));
            keep_in  = (i == 0) ? keep_req : 1'($urandom_range(1));
            if (i == 0)
               to_model = 1'b0;
            i++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("start_pulse", 128'(start), 128'h1);
      check("in_ready_start", 128'(in_ready), 128'h0);
      check("key", key, k);
      check("text", text, t);
      check("enc", 128'(enc), 128'(e));
      if (!use_c) begin
         kv = 1'b1;
         cached_key = k;
      end
      exp_r = core_fn(k, t, e);
      cyc = 0;
      got = 0;
      first = -1;
      timed = 1'b0;
      stalled = 1'b0;
      held = '0;
      while (got < 4 && !timed && cyc < 100) begin
         @(negedge clk);
         cyc++;
         check("start_once", 128'(start), 128'h0);
         if (out_valid) begin
            if (first < 0) begin
               first = cyc;
               check("done_to_valid", 128'(first), 128'(lat + 2));
               check("enc_hold", 128'(enc), 128'(e));
               check("key_hold", key, k);
            end
            if (stalled)
               check("stall_hold", 128'(out_data), 128'(held));
            check($sformatf("out_word%0d", got), 128'(out_data),
                  128'(exp_r[127-32*got -: 32]));
            check("out_last", 128'(out_last), 128'(got == 3));
            check("in_ready_send", 128'(in_ready), 128'h0);
            out_ready = 1'($urandom_range(1));
            stalled = !out_ready;
            held = out_data;
            if (out_ready)
               got++;
         end else begin
            if (timeout)
               timed = 1'b1;
            else
               check("in_ready_wait", 128'(in_ready), 128'h0);
            out_ready = 1'($urandom_range(1));
         end
      end
      if (cyc >= 100)
         check("job_bound", 128'h0, 128'h1);
      check("timed_out", 128'(timed), 128'(lat >= TO));
      if (timed) begin
         check("timeout_cycle", 128'(cyc), 128'(TO + 1));
         check("no_output", 128'(got), 128'h0);
         to_model = 1'b1;
      end
   endtask

   task automatic reset_mid_job();
      int i;
      i = 0;
      @(negedge clk);
      while (i < 5) begin
         if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_enc   = 1'b1;
            keep_in  = 1'b0;
            i++;
         end
         @(negedge clk);
      end
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check_reset("mid_reset");
      kv = 1'b0;
      to_model = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      in_data   = '0;
      in_valid  = 1'b0;
      in_enc    = 1'b0;
      keep_in   = 1'b0;
      out_ready = 1'b0;
      kv        = 1'b0;
      to_model  = 1'b0;
      core_lat  = 0;
      cached_key = '0;
      repeat (2) @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      job(0, 1'b1);
      job(14, 1'b0);
      job(15, 1'b0);
      job(3, 1'b1);
      job(16, 1'b1);
      job(7, 1'b1);
      repeat (30)
         job(($urandom_range(9) == 0) ? 15 + int'($urandom_range(1))
                                       : int'($urandom_range(14)),
             1'($urandom_range(1)));
      reset_mid_job();
      job(5, 1'b1);
      job(2, 1'b1);
      repeat (10)
         job(int'($urandom_range(16)), 1'($urandom_range(1)));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
